// File: rtl/sd_write_pack.sv
// rtl/sd_write_pack.sv - sector write-assembly buffer with req/ack hand-off to the SD write engine
//
// Packs 16-bit words into a 4096-bit sector image and hands it to the SD write engine.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_ready   word write port (accepted while wr_ready=1)
//   load_en/load_data   whole-sector load (read-modify-write base)
//   commit              request commit of the current image
//   sector_out          buffer contents, stable while committing
//   sd_wr_req/sd_wr_ack handshake with the SD write engine
//   done                one-cycle pulse after ack is taken
//   dirty/word_cnt/full fill status since last load/commit/reset

module sd_write_pack #(
  parameter bit AUTO_COMMIT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_addr,
  input  logic [15:0]   wr_data,
  output logic          wr_ready,
  input  logic          load_en,
  input  logic [4095:0] load_data,
  input  logic          commit,
  output logic [4095:0] sector_out,
  output logic          sd_wr_req,
  input  logic          sd_wr_ack,
  output logic          done,
  output logic          dirty,
  output logic [8:0]    word_cnt,
  output logic          full
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [4095:0]   sector_q, sector_d;
  logic [255:0]    mask_q, mask_d;
  logic [8:0]      cnt_q, cnt_d;
  logic            dirty_q, dirty_d;
  logic            done_q, done_d;
  logic            req_q, req_d;
  logic            ready_q, ready_d;
  logic            full_q, full_d;
  logic [11:0]     base;

  // Word bit j lands at sector bit 16w + (15 - j): the stored slice is the word bit-reversed,
  // matching the read divider so a round trip returns the same words.
  function automatic logic [15:0] rev16(input logic [15:0] d);
    logic [15:0] r;
    for (int j = 0; j < 16; j++) begin
      r[15 - j] = d[j];
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    sector_d = sector_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    dirty_d  = dirty_q;
    done_d   = 1'b0;
    base     = {wr_addr, 4'b0000};

    if (state_q != ST_COMMIT) begin
      // Load first so a same-cycle write overlays its word on the fresh image.
      if (load_en) begin
        sector_d = load_data;
        mask_d   = '0;
        cnt_d    = '0;
        dirty_d  = 1'b0;
      end
      if (wr_en) begin
        sector_d[base +: 16] = rev16(wr_data);
        if (!mask_d[wr_addr]) begin
          mask_d[wr_addr] = 1'b1;
          cnt_d           = cnt_d + 9'd1;
        end
        dirty_d = 1'b1;
      end

      // A clean buffer has nothing to commit, so it parks in IDLE and ignores commit.
      if (!dirty_d) begin
        state_d = ST_IDLE;
      end else if (commit || (AUTO_COMMIT && (cnt_d == 9'd256))) begin
        state_d = ST_COMMIT;
      end else begin
        state_d = ST_FILL;
      end
    end else if (sd_wr_ack) begin
      // Sector handed off: bookkeeping clears, image itself is kept.
      mask_d  = '0;
      cnt_d   = '0;
      dirty_d = 1'b0;
      done_d  = 1'b1;
      state_d = ST_IDLE;
    end

    req_d   = (state_d == ST_COMMIT);
    ready_d = (state_d != ST_COMMIT);
    full_d  = (cnt_d == 9'd256);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      sector_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      dirty_q  <= 1'b0;
      done_q   <= 1'b0;
      req_q    <= 1'b0;
      ready_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sector_q <= sector_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      dirty_q  <= dirty_d;
      done_q   <= done_d;
      req_q    <= req_d;
      ready_q  <= ready_d;
      full_q   <= full_d;
    end
  end

  assign sector_out = sector_q;
  assign sd_wr_req  = req_q;
  assign wr_ready   = ready_q;
  assign done       = done_q;
  assign dirty      = dirty_q;
  assign word_cnt   = cnt_q;
  assign full       = full_q;

endmodule

// File: tb/tb_sd_write_pack.sv
// tb/tb_sd_write_pack.sv - directed self-checking bench for sd_write_pack

module tb_sd_write_pack;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [7:0]    wr_addr;
  logic [15:0]   wr_data;
  logic          wr_ready;
  logic          load_en;
  logic [4095:0] load_data;
  logic          commit;
  logic [4095:0] sector_out;
  logic          sd_wr_req;
  logic          sd_wr_ack;
  logic          done;
  logic          dirty;
  logic [8:0]    word_cnt;
  logic          full;

  int checks = 0;
  int errors = 0;

  logic [4095:0] model;
  logic [4095:0] exp_q[$];

  always #5 clk = ~clk;

  sd_write_pack #(.AUTO_COMMIT(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .load_en    (load_en),
    .load_data  (load_data),
    .commit     (commit),
    .sector_out (sector_out),
    .sd_wr_req  (sd_wr_req),
    .sd_wr_ack  (sd_wr_ack),
    .done       (done),
    .dirty      (dirty),
    .word_cnt   (word_cnt),
    .full       (full)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_sector(input string tag, input logic [4095:0] obs, input logic [4095:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed sector differs in %0d bits from expected", tag, $countones(obs ^ exp));
    end
  endtask

  // Reference placement written bit by bit from the mapping rule.
  task automatic mwrite(input logic [7:0] w, input logic [15:0] d);
    for (int j = 0; j < 16; j++) begin
      model[{w, 4'(15 - j)}] = d[j];
    end
  endtask

  // Called with sd_wr_req already high; holds ack low for 'hold' cycles, then acks.
  task automatic finish_commit(input int hold);
    logic [4095:0] e;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("req_hold", 32'(sd_wr_req), 32'd1);
    end
    chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : model;
    chk_sector("sector_at_ack", sector_out, e);
    sd_wr_ack = 1'b1;
    tick();
    sd_wr_ack = 1'b0;
    chk("req_after_ack", 32'(sd_wr_req), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    chk("ready_after_ack", 32'(wr_ready), 32'd1);
    chk("cnt_after_ack", 32'(word_cnt), 32'd0);
    chk("dirty_after_ack", 32'(dirty), 32'd0);
    chk("full_after_ack", 32'(full), 32'd0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] d;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    load_en = 1'b0; load_data = '0; commit = 1'b0; sd_wr_ack = 1'b0;
    model = '0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    chk_sector("rst_sector", sector_out, model);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_req", 32'(sd_wr_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_cnt", 32'(word_cnt), 32'd0);
    chk("rst_dirty", 32'(dirty), 32'd0);
    chk("rst_full", 32'(full), 32'd0);

    // Word 0 mapping
    wr_en = 1'b1; wr_addr = 8'd0; wr_data = 16'h8001;
    mwrite(8'd0, 16'h8001);
    tick();
    wr_en = 1'b0;
    chk("w0_bit0", 32'(sector_out[0]), 32'd1);
    chk("w0_bit15", 32'(sector_out[15]), 32'd1);
    chk_sector("w0_sector", sector_out, model);
    chk("w0_cnt", 32'(word_cnt), 32'd1);
    chk("w0_dirty", 32'(dirty), 32'd1);

    commit = 1'b1;
    exp_q.push_back(model);
    tick();
    commit = 1'b0;
    chk("c1_req", 32'(sd_wr_req), 32'd1);
    chk("c1_ready", 32'(wr_ready), 32'd0);
    finish_commit(2);

    // Top word mapping
    wr_en = 1'b1; wr_addr = 8'd255; wr_data = 16'hA5A5;
    mwrite(8'd255, 16'hA5A5);
    tick();
    wr_en = 1'b0;
    chk("w255_b4080", 32'(sector_out[4080]), 32'd1);
    chk("w255_b4081", 32'(sector_out[4081]), 32'd0);
    chk("w255_b4082", 32'(sector_out[4082]), 32'd1);
    chk("w255_b4087", 32'(sector_out[4087]), 32'd1);
    chk("w255_b4088", 32'(sector_out[4088]), 32'd1);
    chk("w255_cnt", 32'(word_cnt), 32'd1);
    chk_sector("w255_sector", sector_out, model);
    commit = 1'b1;
    exp_q.push_back(model);
    tick();
    commit = 1'b0;
    finish_commit(0);

    // Rewrite same address
    wr_en = 1'b1; wr_addr = 8'd7; wr_data = 16'h1111;
    mwrite(8'd7, 16'h1111);
    tick();
    wr_data = 16'h2222;
    mwrite(8'd7, 16'h2222);
    tick();
    wr_en = 1'b0;
    chk("rw_cnt", 32'(word_cnt), 32'd1);
    chk("rw_word7", 32'(sector_out[127:112]), 32'h4444);
    chk_sector("rw_sector", sector_out, model);

    // Load all-ones then overlay word 3
    load_en = 1'b1; load_data = '1;
    model = '1;
    tick();
    load_en = 1'b0;
    chk("ld_cnt", 32'(word_cnt), 32'd0);
    chk("ld_dirty", 32'(dirty), 32'd0);
    chk_sector("ld_sector", sector_out, model);
    wr_en = 1'b1; wr_addr = 8'd3; wr_data = 16'h0000;
    mwrite(8'd3, 16'h0000);
    tick();
    wr_en = 1'b0;
    chk("ldw_word3", 32'(sector_out[63:48]), 32'h0000);
    chk("ldw_word2", 32'(sector_out[47:32]), 32'hFFFF);
    chk("ldw_cnt", 32'(word_cnt), 32'd1);
    chk_sector("ldw_sector", sector_out, model);

    // Simultaneous load and write
    load_en = 1'b1; load_data = '0;
    wr_en = 1'b1; wr_addr = 8'd9; wr_data = 16'h1234;
    model = '0;
    mwrite(8'd9, 16'h1234);
    tick();
    load_en = 1'b0; wr_en = 1'b0;
    chk("lw_cnt", 32'(word_cnt), 32'd1);
    chk("lw_dirty", 32'(dirty), 32'd1);
    chk_sector("lw_sector", sector_out, model);

    // Simultaneous write and commit
    wr_en = 1'b1; wr_addr = 8'd10; wr_data = 16'hBEEF; commit = 1'b1;
    mwrite(8'd10, 16'hBEEF);
    exp_q.push_back(model);
    tick();
    wr_en = 1'b0; commit = 1'b0;
    chk("wc_req", 32'(sd_wr_req), 32'd1);
    finish_commit(1);

    // Commit on a clean buffer, stray ack outside COMMIT
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("clean_commit_req", 32'(sd_wr_req), 32'd0);
    tick();
    chk("clean_commit_done", 32'(done), 32'd0);
    sd_wr_ack = 1'b1;
    tick();
    sd_wr_ack = 1'b0;
    chk("stray_ack_done", 32'(done), 32'd0);
    chk("stray_ack_ready", 32'(wr_ready), 32'd1);

    // Fill all 256 words, auto commit
    for (int i = 0; i < 256; i++) begin
      d = 16'($urandom);
      wr_en = 1'b1; wr_addr = 8'(i); wr_data = d;
      mwrite(8'(i), d);
      if (i == 255) exp_q.push_back(model);
      tick();
      if (i == 254) begin
        chk("fill254_req", 32'(sd_wr_req), 32'd0);
        chk("fill254_full", 32'(full), 32'd0);
        chk("fill254_cnt", 32'(word_cnt), 32'd255);
      end
    end
    wr_en = 1'b0;
    chk("fill_req", 32'(sd_wr_req), 32'd1);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ready", 32'(wr_ready), 32'd0);
    chk("fill_cnt", 32'(word_cnt), 32'd256);
    // Dropped write during COMMIT: model left unchanged
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = ~sector_out[95:80];
    tick();
    wr_en = 1'b0;
    chk("drop_req", 32'(sd_wr_req), 32'd1);
    finish_commit(4);

    // Reset in the middle of COMMIT
    wr_en = 1'b1; wr_addr = 8'd1; wr_data = 16'h00F0;
    mwrite(8'd1, 16'h00F0);
    tick();
    wr_en = 1'b0; commit = 1'b1;
    exp_q.push_back(model);
    tick();
    commit = 1'b0;
    chk("rc_req", 32'(sd_wr_req), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    model = '0;
    chk("rc_req_dropped", 32'(sd_wr_req), 32'd0);
    chk_sector("rc_sector", sector_out, model);
    chk("rc_cnt", 32'(word_cnt), 32'd0);
    chk("rc_ready", 32'(wr_ready), 32'd1);
    sd_wr_ack = 1'b1;
    tick();
    sd_wr_ack = 1'b0;
    chk("rc_late_ack_done", 32'(done), 32'd0);
    tick();
    chk("rc_late_ack_done2", 32'(done), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sd_write_pack.md
# sd_write_pack

Sector write-assembly buffer for the SD storage path. Accepts 16-bit words from the cache/memory side at word addresses 0–255 and packs them into a 4096-bit (512-byte) sector image. It then hands the completed sector to the SD write engine under a req/ack handshake. Bit placement is the exact inverse of the sector read divider, so a sector written here and read back returns identical words at identical addresses.

## Interface
Parameters:
- AUTO_COMMIT, 1, when 1 the block enters COMMIT automatically on the cycle all 256 words have been written; when 0 only `commit` starts a commit.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  synchronous reset, active-low; one clock, one reset, polarity and synchronicity fixed
- wr_en  in  1  word write strobe, honoured only while wr_ready=1
- wr_addr  in  8  word index within sector
- wr_data  in  16  word to store
- wr_ready  out  1  high in IDLE and FILL, low in COMMIT
- load_en  in  1  load whole sector image (read-modify-write base), honoured in IDLE/FILL
- load_data  in  4096  sector image from SD read path
- commit  in  1  request commit of current image
- sector_out  out  4096  current buffer contents, held stable during COMMIT
- sd_wr_req  out  1  sector valid, request to SD write engine
- sd_wr_ack  in  1  SD write engine has taken sector_out
- done  out  1  one-cycle pulse after ack accepted
- dirty  out  1  buffer modified since last load/commit/reset
- word_cnt  out  9  number of distinct words written since last load/commit/reset (0–256)
- full  out  1  word_cnt == 256

## Operation
- Bit mapping: word w, bit j of wr_data goes to sector_out[{w,4'(15-j)}]. wr_data[15] lands at sector_out[16w], and wr_data[0] lands at sector_out[16w+15].
- State machine IDLE, FILL, COMMIT:
  - IDLE: buffer clean, word_cnt=0. A write moves to FILL. A load stays in IDLE, since dirty stays 0.
  - FILL: writes and loads accepted. Commit goes to COMMIT. With AUTO_COMMIT=1, full goes to COMMIT.
  - COMMIT: sd_wr_req=1, writes/loads/commit ignored. On sampled sd_wr_ack=1: clear mask, word_cnt, dirty; go to IDLE; done=1 next cycle. Buffer contents are retained.
- Written-word mask, 256 bits: word_cnt increments only on the first write to an address. Rewriting the same address updates data but not the count.
- load_en: buffer ← load_data, mask cleared, word_cnt=0, dirty=0.
- Simultaneous load_en and wr_en: the load is applied first, then the write overlays its word. Result: mask has that word set, word_cnt=1, dirty=1.
- Simultaneous wr_en and commit in FILL: the write is applied, then the block enters COMMIT, and sector_out includes the write.
- commit while dirty=0, in IDLE: ignored. No request, no done.
- Writes, loads and commits presented during COMMIT are dropped, not queued.
- sd_wr_ack while not in COMMIT is ignored.

## Timing
- Reset (rst_n=0 at edge):
  - state IDLE
  - sector_out all 0
  - mask 0, word_cnt 0
  - full 0, dirty 0
  - sd_wr_req 0, done 0
  - wr_ready 1
- Reset mid-COMMIT drops sd_wr_req the cycle after the reset edge. The sector is discarded.
- Write at edge N: sector_out, word_cnt, dirty and full are updated after edge N.
- Commit, or the final write with AUTO_COMMIT=1, at edge N: sd_wr_req=1 and wr_ready=0 from after edge N.
- sd_wr_req stays high until ack is sampled at edge M. After edge M: sd_wr_req=0, state IDLE, wr_ready=1, done=1 for exactly one cycle.
- sector_out is constant from the commit edge through the ack edge.
- Ack in the same cycle req rises is legal. Minimum commit duration is 1 cycle.

## Test plan
- Reset, then write addr 0 data 16'h8001 → sector_out[0]=1, sector_out[15]=1, all other bits 0; word_cnt=1, dirty=1.
- Write addr 255 data 16'hA5A5 → sector_out[4095:4080]=16'hA5A5 bit-reversed, i.e. sector_out[4080]=1, [4081]=0, [4082]=1, [4087]=1, [4088]=1; word_cnt=1.
- Write addr 7 twice (16'h1111 then 16'h2222) → word_cnt=1, word 7 holds 16'h2222.
- Load an all-ones image, then write addr 3 data 16'h0000 → only bits 48–63 become 0; word_cnt=1.
- AUTO_COMMIT=1, write 256 distinct addresses, hold sd_wr_ack=0 for 5 cycles, then pulse it:
  - sd_wr_req rises the cycle after the 256th write; full=1.
  - A write attempted during COMMIT is dropped.
  - done pulses once; word_cnt returns to 0.
- Commit then assert rst_n=0 before ack → sd_wr_req=0 and sector_out=0 after the reset edge. A later ack produces no done.
